// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the ALU issue sequencer and its register file:
//   - fixed widths (4-bit data, 4 registers, 3-bit opcode, 9-bit instruction)
//   - opcode constants understood by the downstream Decode_And_Execute ALU
//   - sequencer state encoding
//   - instruction field positions and small field-extraction helpers
// No ports (package).
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

   localparam int DATA_W   = 4;
   localparam int RF_AW    = 2;
   localparam int RF_DEPTH = 4;
   localparam int OP_W     = 3;
   localparam int INSTR_W  = 9;

   // Opcodes as decoded by the ALU.
   localparam logic [OP_W-1:0] OP_ADD = 3'b000;  // rs + rt mod 16
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;  // rs - rt mod 16
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_ROL = 3'b100;  // rotate rs left by 1
   localparam logic [OP_W-1:0] OP_ASR = 3'b101;  // arithmetic shift rt right by 1
   localparam logic [OP_W-1:0] OP_EQ  = 3'b110;  // {3'b111, rs == rt}
   localparam logic [OP_W-1:0] OP_GT  = 3'b111;  // {3'b101, rs > rt}, unsigned

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10
   } state_t;

   // Instruction layout: [8:6] op, [5:4] dst, [3:2] src_s, [1:0] src_t
   localparam int OP_LSB   = 6;
   localparam int DST_LSB  = 4;
   localparam int SRCS_LSB = 2;
   localparam int SRCT_LSB = 0;

   function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_LSB +: OP_W];
   endfunction

   function automatic logic [RF_AW-1:0] instr_dst(input logic [INSTR_W-1:0] instr);
      return instr[DST_LSB +: RF_AW];
   endfunction

   function automatic logic [RF_AW-1:0] instr_src_s(input logic [INSTR_W-1:0] instr);
      return instr[SRCS_LSB +: RF_AW];
   endfunction

   function automatic logic [RF_AW-1:0] instr_src_t(input logic [INSTR_W-1:0] instr);
      return instr[SRCT_LSB +: RF_AW];
   endfunction

   function automatic logic [INSTR_W-1:0] instr_pack(input logic [OP_W-1:0]  op,
                                                     input logic [RF_AW-1:0] dst,
                                                     input logic [RF_AW-1:0] src_s,
                                                     input logic [RF_AW-1:0] src_t);
      return {op, dst, src_s, src_t};
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_rf4x4.sv
// -----------------------------------------------------------------------------
// rf4x4
// 4-entry x 4-bit register file for the ALU issue sequencer.
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low clear
//   ra_addr / ra_data    async read port A (operand rs)
//   rb_addr / rb_data    async read port B (operand rt)
//   dbg_addr / dbg_data  async debug read port
//   wb_en/wb_addr/wb_data  write port 0 (ALU writeback, higher priority)
//   ld_en/ld_addr/ld_data  write port 1 (direct load)
// Reads return the pre-edge contents; there is no write-to-read bypass.
// -----------------------------------------------------------------------------
module rf4x4
   import alu_issue_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [RF_AW-1:0]  ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [RF_AW-1:0]  rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [RF_AW-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   input  logic              wb_en,
   input  logic [RF_AW-1:0]  wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              ld_en,
   input  logic [RF_AW-1:0]  ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   logic [DATA_W-1:0] mem [RF_DEPTH];

   assign ra_data  = mem[ra_addr];
   assign rb_data  = mem[rb_addr];
   assign dbg_data = mem[dbg_addr];

   // Per-entry write select: a writeback to the same entry as a load wins,
   // loads to other entries still land in the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < RF_DEPTH; i++) begin
            if (wb_en && (wb_addr == RF_AW'(i))) begin
               mem[i] <= wb_data;
            end else if (ld_en && (ld_addr == RF_AW'(i))) begin
               mem[i] <= ld_data;
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Single-issue sequencer in front of the 4-bit Decode_And_Execute ALU. Accepts
// one instruction per valid/ready handshake, reads both operands from the
// local register file, presents them (registered) to the ALU, captures the
// ALU result one cycle later and writes it back, pulsing done_valid in the
// writeback cycle. One instruction every 3 cycles: IDLE -> EXEC -> WB.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       instruction handshake (in_ready high only in IDLE)
//   in_instr[8:0]           {op, dst, src_s, src_t}, sampled at accept only
//   ld_en/ld_addr/ld_data   direct register load, honoured in any state
//   alu_rs/alu_rt/alu_sel   registered operands/opcode to the ALU
//   alu_rd                  combinational result back from the ALU
//   done_valid/addr/data    one-cycle completion report (WB cycle)
//   rf_raddr/rf_rdata       combinational debug read of the register file
// -----------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic               ld_en,
   input  logic [RF_AW-1:0]   ld_addr,
   input  logic [DATA_W-1:0]  ld_data,
   output logic [DATA_W-1:0]  alu_rs,
   output logic [DATA_W-1:0]  alu_rt,
   output logic [OP_W-1:0]    alu_sel,
   input  logic [DATA_W-1:0]  alu_rd,
   output logic               done_valid,
   output logic [RF_AW-1:0]   done_addr,
   output logic [DATA_W-1:0]  done_data,
   input  logic [RF_AW-1:0]   rf_raddr,
   output logic [DATA_W-1:0]  rf_rdata
);

   state_t             state;
   state_t             state_nxt;
   logic               accept;
   logic               wb_en;

   logic [OP_W-1:0]    op_in;
   logic [RF_AW-1:0]   dst_in;
   logic [RF_AW-1:0]   src_s_in;
   logic [RF_AW-1:0]   src_t_in;
   logic [DATA_W-1:0]  rs_val;
   logic [DATA_W-1:0]  rt_val;

   logic [RF_AW-1:0]   dst_p0;
   logic [DATA_W-1:0]  result_p1;

   assign op_in    = instr_op(in_instr);
   assign dst_in   = instr_dst(in_instr);
   assign src_s_in = instr_src_s(in_instr);
   assign src_t_in = instr_src_t(in_instr);

   // Operand reads are driven straight from the incoming instruction so the
   // accept edge captures the pre-edge register contents, even if a load to
   // the same register lands on that edge.
   rf4x4 u_rf (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra_addr  (src_s_in),
      .ra_data  (rs_val),
      .rb_addr  (src_t_in),
      .rb_data  (rt_val),
      .dbg_addr (rf_raddr),
      .dbg_data (rf_rdata),
      .wb_en    (wb_en),
      .wb_addr  (dst_p0),
      .wb_data  (result_p1),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      done_valid = 1'b0;
      wb_en      = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_nxt = ST_WB;
         end
         ST_WB: begin
            done_valid = 1'b1;
            wb_en      = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign accept = in_valid & in_ready;

   // ---- stage p0: operand issue (accept edge) ----
   // Operands and opcode hold their last values outside the accept edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_rs  <= '0;
         alu_rt  <= '0;
         alu_sel <= '0;
         dst_p0  <= '0;
      end else if (accept) begin
         alu_rs  <= rs_val;
         alu_rt  <= rt_val;
         alu_sel <= op_in;
         dst_p0  <= dst_in;
      end
   end

   // ---- stage p1: result capture (end of EXEC) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_p1 <= '0;
      end else if (state == ST_EXEC) begin
         result_p1 <= alu_rd;
      end
   end

   // ---- writeback / completion (WB cycle) ----
   assign done_addr = dst_p0;
   assign done_data = result_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Bench for alu_issue_ctrl with a behavioural stand-in for the 4-bit ALU.
// The reference model tracks the register file as an array and the in-flight
// instruction as a snapshot plus an age counted in clock edges since accept.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;
   import alu_issue_ctrl_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [8:0] in_instr;
   logic       ld_en;
   logic [1:0] ld_addr;
   logic [3:0] ld_data;
   logic [3:0] alu_rs;
   logic [3:0] alu_rt;
   logic [2:0] alu_sel;
   logic [3:0] alu_rd;
   logic       done_valid;
   logic [1:0] done_addr;
   logic [3:0] done_data;
   logic [1:0] rf_raddr;
   logic [3:0] rf_rdata;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [3:0] m_rf [4];
   logic [3:0] m_rs, m_rt;
   logic [2:0] m_sel;
   logic [1:0] m_dst;
   int         m_age;      // edges since last accept; >= 3 means idle

   logic       obs_done_valid;
   logic [3:0] obs_done_data;
   logic       obs_accept;

   alu_issue_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .alu_rs     (alu_rs),
      .alu_rt     (alu_rt),
      .alu_sel    (alu_sel),
      .alu_rd     (alu_rd),
      .done_valid (done_valid),
      .done_addr  (done_addr),
      .done_data  (done_data),
      .rf_raddr   (rf_raddr),
      .rf_rdata   (rf_rdata)
   );

   function automatic logic [3:0] alu_f(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
      logic signed [3:0] sb;
      sb = b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return {a[2:0], a[3]};
         3'd5:    return sb >>> 1;
         3'd6:    return {3'b111, (a == b)};
         default: return {3'b101, (a > b)};
      endcase
   endfunction

   // Behavioural ALU in the parent's place.
   assign alu_rd = alu_f(alu_sel, alu_rs, alu_rt);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 4'h0;
      m_rs  = 4'h0;
      m_rt  = 4'h0;
      m_sel = 3'h0;
      m_dst = 2'h0;
      m_age = 3;
   endtask

   // One clock cycle: drive inputs, compare outputs against the model,
   // advance the model across the edge, then take the edge.
   task automatic cycle(input logic v, input logic [8:0] ins, input logic le,
                        input logic [1:0] la, input logic [3:0] ldv, input logic [1:0] ra);
      logic       exp_ready, exp_done;
      logic [3:0] res;
      logic [1:0] old_dst;
      in_valid = v;
      in_instr = ins;
      ld_en    = le;
      ld_addr  = la;
      ld_data  = ldv;
      rf_raddr = ra;
      #1;
      exp_ready = (m_age >= 3);
      exp_done  = (m_age == 2);
      res       = alu_f(m_sel, m_rs, m_rt);
      check_val("in_ready",   8'(in_ready),   8'(exp_ready));
      check_val("done_valid", 8'(done_valid), 8'(exp_done));
      check_val("alu_rs",     8'(alu_rs),     8'(m_rs));
      check_val("alu_rt",     8'(alu_rt),     8'(m_rt));
      check_val("alu_sel",    8'(alu_sel),    8'(m_sel));
      check_val("rf_rdata",   8'(rf_rdata),   8'(m_rf[ra]));
      if (exp_done) begin
         check_val("done_addr", 8'(done_addr), 8'(m_dst));
         check_val("done_data", 8'(done_data), 8'(res));
      end
      obs_done_valid = done_valid;
      obs_done_data  = done_data;
      obs_accept     = in_valid & in_ready;
      old_dst = m_dst;
      if (v && exp_ready) begin
         m_rs  = m_rf[ins[3:2]];
         m_rt  = m_rf[ins[1:0]];
         m_sel = ins[8:6];
         m_dst = ins[5:4];
         m_age = 1;
      end else if (m_age < 3) begin
         m_age++;
      end
      if (le) m_rf[la] = ldv;
      if (exp_done) m_rf[old_dst] = res;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [1:0] ra);
      cycle(1'b0, 9'h0, 1'b0, 2'd0, 4'h0, ra);
   endtask

   task automatic load(input logic [1:0] a, input logic [3:0] d);
      cycle(1'b0, 9'h0, 1'b1, a, d, a);
   endtask

   // Issue from IDLE, run through WB; optional load during the WB cycle.
   task automatic run_op(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s,
                         input logic [1:0] t, input logic wle, input logic [1:0] wla,
                         input logic [3:0] wld, output logic [3:0] data);
      cycle(1'b1, instr_pack(op, d, s, t), 1'b0, 2'd0, 4'h0, d);
      idle(d);
      cycle(1'b0, 9'h0, wle, wla, wld, d);
      check_val("wb_pulse", 8'(obs_done_valid), 8'd1);
      data = obs_done_data;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_ready"}, 8'(in_ready),   8'd1);
      check_val({tag, "_done"},  8'(done_valid), 8'd0);
      check_val({tag, "_daddr"}, 8'(done_addr),  8'd0);
      check_val({tag, "_ddata"}, 8'(done_data),  8'd0);
      check_val({tag, "_rs"},    8'(alu_rs),     8'd0);
      check_val({tag, "_rt"},    8'(alu_rt),     8'd0);
      check_val({tag, "_sel"},   8'(alu_sel),    8'd0);
      for (int a = 0; a < 4; a++) begin
         rf_raddr = 2'(a);
         #1;
         check_val({tag, "_rf"}, 8'(rf_rdata), 8'd0);
      end
   endtask

   initial begin
      logic [3:0] r;
      int         acc_cnt;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_instr = 9'h0;
      ld_en    = 1'b0;
      ld_addr  = 2'd0;
      ld_data  = 4'h0;
      rf_raddr = 2'd0;
      model_reset();
      #1;
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic arithmetic
      load(2'd1, 4'd5);
      load(2'd2, 4'd3);
      run_op(OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 4'h0, r);
      check_val("add_data", 8'(r), 8'h8);
      check_val("add_rf0", 8'(rf_rdata), 8'h8);
      run_op(OP_SUB, 2'd3, 2'd2, 2'd1, 1'b0, 2'd0, 4'h0, r);
      check_val("sub_data", 8'(r), 8'hE);
      run_op(OP_EQ, 2'd0, 2'd1, 2'd1, 1'b0, 2'd0, 4'h0, r);
      check_val("eq_data", 8'(r), 8'hF);
      run_op(OP_GT, 2'd1, 2'd1, 2'd2, 1'b0, 2'd0, 4'h0, r);
      check_val("gt_data", 8'(r), 8'hB);
      check_val("gt_rf1", 8'(rf_rdata), 8'hB);

      // Writeback vs load collisions (R1=11, R2=3)
      run_op(OP_ADD, 2'd2, 2'd1, 2'd2, 1'b1, 2'd2, 4'd7, r);
      check_val("coll_data", 8'(r), 8'hE);
      check_val("coll_rf2", 8'(rf_rdata), 8'hE);
      run_op(OP_ADD, 2'd2, 2'd1, 2'd2, 1'b1, 2'd3, 4'd7, r);
      check_val("both_rf2", 8'(rf_rdata), 8'h9);
      idle(2'd3);
      check_val("both_rf3", 8'(rf_rdata), 8'h7);

      // Held in_valid: exactly one accept per three cycles
      acc_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 9'($urandom), 1'b0, 2'd0, 4'h0, 2'($urandom));
         if (obs_accept) acc_cnt++;
      end
      check_val("held_accepts", 8'(acc_cnt), 8'd4);
      idle(2'd0);

      // Rotate / arithmetic shift
      load(2'd0, 4'b1001);
      run_op(OP_ROL, 2'd1, 2'd0, 2'd0, 1'b0, 2'd0, 4'h0, r);
      check_val("rol_data", 8'(r), 8'b0011);
      run_op(OP_ASR, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 4'h0, r);
      check_val("asr_data", 8'(r), 8'b1100);

      // Asynchronous reset while in EXEC
      cycle(1'b1, instr_pack(OP_ADD, 2'd3, 2'd1, 2'd2), 1'b0, 2'd0, 4'h0, 2'd0);
      in_valid = 1'b0;
      ld_en    = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_reset_outputs("mid");
      model_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(2'd3);
      idle(2'd3);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 9) < 7), 9'($urandom), ($urandom_range(0, 9) < 3),
               2'($urandom), 4'($urandom), 2'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
